// File: rtl/icache_pkg.sv
// ============================================================================
// Module      : icache_pkg
// Description : Shared widths, FSM state encoding and PLRU helpers for the
//               set-associative L1 instruction cache.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package icache_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int LINE_W_DEF = 256;
    localparam int SETS_DEF   = 512;
    localparam int WAYS_DEF   = 2;

    function automatic int calc_off_w(input int line_w);
        return $clog2(line_w / 8);
    endfunction

    function automatic int calc_idx_w(input int sets);
        return $clog2(sets);
    endfunction

    localparam int OFF_W = calc_off_w(LINE_W_DEF);
    localparam int IDX_W = calc_idx_w(SETS_DEF);
    localparam int TAG_W = ADDR_W_DEF - IDX_W - OFF_W;
    localparam int WPL   = LINE_W_DEF / 32;
    localparam int LRU_W = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MISS  = 2'd1,
        WAIT  = 2'd2,
        FLUSH = 2'd3
    } state_e;

    // Tree bits point at the side holding the next victim: bit0 selects the
    // half, bit1 picks within ways 0/1, bit2 within ways 2/3.
    function automatic logic [LRU_W-1:0] plru_update(input logic [LRU_W-1:0] s,
                                                     input logic [1:0]       way,
                                                     input int               ways);
        logic [LRU_W-1:0] r;
        r = s;
        if (ways == 2) begin
            r[0] = ~way[0];
        end else if (ways == 4) begin
            r[0] = ~way[1];
            if (!way[1]) r[1] = ~way[0];
            else         r[2] = ~way[0];
        end
        return r;
    endfunction

    function automatic logic [1:0] plru_victim(input logic [LRU_W-1:0] s,
                                               input int               ways);
        logic [1:0] v;
        v = 2'd0;
        if (ways == 2)      v = {1'b0, s[0]};
        else if (ways == 4) v = s[0] ? {1'b1, s[2]} : {1'b0, s[1]};
        return v;
    endfunction

endpackage

`default_nettype wire

// File: rtl/icache_way.sv
// ============================================================================
// Module      : icache_way
// Description : One cache way: valid vector, tag and data arrays with a
//               combinational read port and one registered write port.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module icache_way #(
    parameter int TAG_BITS = 18,
    parameter int IDX_BITS = 9,
    parameter int LINE_W   = 256,
    parameter int SETS     = 512
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [IDX_BITS-1:0] rd_idx_i,
    output logic                valid_o,
    output logic [TAG_BITS-1:0] tag_o,
    output logic [LINE_W-1:0]   data_o,
    input  logic [IDX_BITS-1:0] wr_idx_i,
    input  logic                fill_i,
    input  logic                clr_i,
    input  logic [TAG_BITS-1:0] wr_tag_i,
    input  logic [LINE_W-1:0]   wr_data_i
);

    logic [SETS-1:0]     valid_q;
    logic [TAG_BITS-1:0] tag_q  [SETS];
    logic [LINE_W-1:0]   data_q [SETS];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q <= '0;
        end else if (fill_i) begin
            valid_q[wr_idx_i] <= 1'b1;
        end else if (clr_i) begin
            valid_q[wr_idx_i] <= 1'b0;
        end
    end

    // Tag and data storage carry no reset; validity alone qualifies them.
    always_ff @(posedge clk_i) begin
        if (fill_i) begin
            tag_q[wr_idx_i]  <= wr_tag_i;
            data_q[wr_idx_i] <= wr_data_i;
        end
    end

    assign valid_o = valid_q[rd_idx_i];
    assign tag_o   = tag_q[rd_idx_i];
    assign data_o  = data_q[rd_idx_i];

endmodule

`default_nettype wire

// File: rtl/icache_l1_assoc.sv
// ============================================================================
// Module      : icache_l1_assoc
// Description : Set-associative L1 instruction cache with PLRU replacement,
//               combinational hit path, handshaked line fill and full flush.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module icache_l1_assoc #(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 256,
    parameter int SETS   = 512,
    parameter int WAYS   = 2
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              req_valid,
    input  logic [ADDR_W-1:0] instr_addressIF,
    input  logic              flush,
    output logic [31:0]       instr_out,
    output logic              hit,
    output logic              stall,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_address,
    input  logic [LINE_W-1:0] mem_data,
    input  logic              mem_valid
);

    import icache_pkg::*;

    localparam int OFF_BITS = calc_off_w(LINE_W);
    localparam int IDX_BITS = calc_idx_w(SETS);
    localparam int TAG_BITS = ADDR_W - IDX_BITS - OFF_BITS;
    localparam int WORDS    = LINE_W / 32;
    localparam int WSEL_W   = (OFF_BITS > 2) ? OFF_BITS - 2 : 1;

    state_e              state_q, state_d;
    logic [IDX_BITS-1:0] idx_q, idx_d;
    logic [TAG_BITS-1:0] tag_q, tag_d;
    logic [1:0]          victim_q, victim_d;
    logic                flush_pend_q, flush_pend_d;
    logic [IDX_BITS-1:0] flush_cnt_q, flush_cnt_d;
    logic                mem_req_q, mem_req_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [LRU_W-1:0]    lru_q [SETS];

    logic [TAG_BITS-1:0] w_tag;
    logic [IDX_BITS-1:0] w_idx;
    logic [WSEL_W-1:0]   w_word;
    logic                w_unused;

    logic [WAYS-1:0]     w_rd_valid;
    logic [TAG_BITS-1:0] w_rd_tag  [WAYS];
    logic [LINE_W-1:0]   w_rd_data [WAYS];
    logic [WAYS-1:0]     w_way_hit;
    logic                w_any_hit;
    logic [1:0]          w_hit_way;
    logic [LINE_W-1:0]   w_line;
    logic [31:0]         w_words [WORDS];
    logic [1:0]          w_victim;
    logic                w_found;

    logic                w_fill;
    logic                w_clr;
    logic [IDX_BITS-1:0] w_wr_idx;
    logic                w_lru_we;
    logic [IDX_BITS-1:0] w_lru_idx;
    logic [LRU_W-1:0]    w_lru_val;

    assign w_tag    = instr_addressIF[ADDR_W-1 -: TAG_BITS];
    assign w_idx    = instr_addressIF[OFF_BITS +: IDX_BITS];
    assign w_unused = ^instr_addressIF[1:0];

    if (OFF_BITS > 2) begin : g_word_sel
        assign w_word = instr_addressIF[OFF_BITS-1:2];
    end else begin : g_word_single
        assign w_word = '0;
    end

    assign w_wr_idx = (state_q == FLUSH) ? flush_cnt_q : idx_q;

    for (genvar w = 0; w < WAYS; w++) begin : g_way
        icache_way #(
            .TAG_BITS (TAG_BITS),
            .IDX_BITS (IDX_BITS),
            .LINE_W   (LINE_W),
            .SETS     (SETS)
        ) u_way (
            .clk_i     (CLK),
            .rst_i     (RESET),
            .rd_idx_i  (w_idx),
            .valid_o   (w_rd_valid[w]),
            .tag_o     (w_rd_tag[w]),
            .data_o    (w_rd_data[w]),
            .wr_idx_i  (w_wr_idx),
            .fill_i    (w_fill && (victim_q == 2'(w))),
            .clr_i     (w_clr),
            .wr_tag_i  (tag_q),
            .wr_data_i (mem_data)
        );
    end

    // Lowest-numbered matching way wins; with no match way 0 drives the output.
    always_comb begin
        w_way_hit = '0;
        w_any_hit = 1'b0;
        w_hit_way = 2'd0;
        w_line    = w_rd_data[0];
        for (int w = 0; w < WAYS; w++) begin
            w_way_hit[w] = w_rd_valid[w] && (w_rd_tag[w] == w_tag);
            if (w_way_hit[w] && !w_any_hit) begin
                w_any_hit = 1'b1;
                w_hit_way = 2'(w);
                w_line    = w_rd_data[w];
            end
        end
    end

    for (genvar k = 0; k < WORDS; k++) begin : g_words
        assign w_words[k] = w_line[LINE_W-1-32*k -: 32];
    end

    assign hit         = w_any_hit && (state_q == IDLE);
    assign instr_out   = w_words[w_word];
    assign stall       = (req_valid && !hit) || (state_q != IDLE);
    assign mem_req     = mem_req_q;
    assign mem_address = mem_addr_q;

    always_comb begin
        w_victim = plru_victim(lru_q[w_idx], WAYS);
        w_found  = 1'b0;
        for (int w = 0; w < WAYS; w++) begin
            if (!w_found && !w_rd_valid[w]) begin
                w_victim = 2'(w);
                w_found  = 1'b1;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        tag_d        = tag_q;
        victim_d     = victim_q;
        flush_pend_d = flush_pend_q;
        flush_cnt_d  = flush_cnt_q;
        mem_req_d    = mem_req_q;
        mem_addr_d   = mem_addr_q;
        w_fill       = 1'b0;
        w_clr        = 1'b0;
        w_lru_we     = 1'b0;
        w_lru_idx    = w_idx;
        w_lru_val    = plru_update(lru_q[w_idx], w_hit_way, WAYS);

        case (state_q)
            IDLE: begin
                w_lru_we = req_valid && hit;
                if (flush) begin
                    state_d     = FLUSH;
                    flush_cnt_d = '0;
                end else if (req_valid && !hit) begin
                    state_d    = MISS;
                    idx_d      = w_idx;
                    tag_d      = w_tag;
                    victim_d   = w_victim;
                    mem_req_d  = 1'b1;
                    mem_addr_d = {w_tag, w_idx, {OFF_BITS{1'b0}}};
                end
            end
            MISS: begin
                if (flush) flush_pend_d = 1'b1;
                state_d = WAIT;
            end
            WAIT: begin
                if (flush) flush_pend_d = 1'b1;
                if (mem_valid) begin
                    w_fill     = 1'b1;
                    w_lru_we   = 1'b1;
                    w_lru_idx  = idx_q;
                    w_lru_val  = plru_update(lru_q[idx_q], victim_q, WAYS);
                    mem_req_d  = 1'b0;
                    mem_addr_d = '0;
                    if (flush_pend_q || flush) begin
                        state_d      = FLUSH;
                        flush_cnt_d  = '0;
                        flush_pend_d = 1'b0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            FLUSH: begin
                w_clr = 1'b1;
                if (flush_cnt_q == IDX_BITS'(SETS - 1)) state_d = IDLE;
                else flush_cnt_d = flush_cnt_q + 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            tag_q        <= '0;
            victim_q     <= 2'd0;
            flush_pend_q <= 1'b0;
            flush_cnt_q  <= '0;
            mem_req_q    <= 1'b0;
            mem_addr_q   <= '0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            tag_q        <= tag_d;
            victim_q     <= victim_d;
            flush_pend_q <= flush_pend_d;
            flush_cnt_q  <= flush_cnt_d;
            mem_req_q    <= mem_req_d;
            mem_addr_q   <= mem_addr_d;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            for (int s = 0; s < SETS; s++) lru_q[s] <= '0;
        end else if (w_lru_we) begin
            lru_q[w_lru_idx] <= w_lru_val;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_icache_l1_assoc.sv
// ============================================================================
// Module      : tb_icache_l1_assoc
// Description : Scoreboard bench for the L1 instruction cache: fills, word
//               select, PLRU eviction, flush, flush-during-fill, async reset.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_icache_l1_assoc;

    localparam int ADDR_W = 32;
    localparam int LINE_W = 256;
    localparam int SETS   = 512;
    localparam int WAYS   = 2;

    logic              CLK = 1'b0;
    logic              RESET;
    logic              req_valid;
    logic [ADDR_W-1:0] instr_addressIF;
    logic              flush;
    logic [31:0]       instr_out;
    logic              hit;
    logic              stall;
    logic              mem_req;
    logic [ADDR_W-1:0] mem_address;
    logic [LINE_W-1:0] mem_data;
    logic              mem_valid;

    always #5 CLK = ~CLK;

    icache_l1_assoc #(
        .ADDR_W (ADDR_W),
        .LINE_W (LINE_W),
        .SETS   (SETS),
        .WAYS   (WAYS)
    ) dut (
        .CLK             (CLK),
        .RESET           (RESET),
        .req_valid       (req_valid),
        .instr_addressIF (instr_addressIF),
        .flush           (flush),
        .instr_out       (instr_out),
        .hit             (hit),
        .stall           (stall),
        .mem_req         (mem_req),
        .mem_address     (mem_address),
        .mem_data        (mem_data),
        .mem_valid       (mem_valid)
    );

    typedef struct packed {
        logic [31:0] addr;
        logic        miss;
        logic [31:0] instr;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Backing-memory contents: the 0x40 line holds 0x11111111..0x88888888,
    // every other word holds its own address tagged with 0xC in the top nibble.
    function automatic logic [31:0] exp_word(input logic [31:0] a);
        logic [31:0] k;
        k = {29'd0, a[4:2]};
        if ({a[31:5], 5'd0} == 32'h0000_0040) return 32'h1111_1111 * (k + 1);
        return {a[31:2], 2'b00} | 32'hC000_0000;
    endfunction

    function automatic logic [LINE_W-1:0] gen_line(input logic [31:0] la);
        logic [LINE_W-1:0] l;
        for (int k = 0; k < LINE_W / 32; k++)
            l[LINE_W-1-32*k -: 32] = exp_word({la[31:5], 5'd0} + 32'(4 * k));
        return l;
    endfunction

    task automatic access(input logic [31:0] a, input logic exp_miss, input int lat);
        exp_t e;
        sb_q.push_back('{addr: a, miss: exp_miss, instr: exp_word(a)});
        @(negedge CLK);
        req_valid = 1'b1;
        instr_addressIF = a;
        #1;
        e = sb_q.pop_front();
        chk("hit", 64'(hit), 64'(!e.miss));
        if (!hit) begin
            chk("stall_on_miss", 64'(stall), 64'd1);
            @(posedge CLK); #1;
            chk("mem_req", 64'(mem_req), 64'd1);
            chk("mem_address", 64'(mem_address), 64'({e.addr[31:5], 5'd0}));
            repeat (lat) @(posedge CLK);
            @(negedge CLK);
            mem_data  = gen_line(e.addr);
            mem_valid = 1'b1;
            @(posedge CLK); #1;
            mem_valid = 1'b0;
            chk("mem_req_drop", 64'(mem_req), 64'd0);
            chk("refill_hit", 64'(hit), 64'd1);
        end
        chk("instr", 64'(instr_out), 64'(e.instr));
        @(negedge CLK);
        req_valid = 1'b0;
    endtask

    task automatic flush_wait(input string tag, input bit reflush);
        int n;
        n = 0;
        while (stall && n < SETS + 16) begin
            n++;
            flush = reflush && (n == 10);
            @(posedge CLK); #1;
        end
        flush = 1'b0;
        chk(tag, 64'(n), 64'(SETS));
    endtask

    initial begin
        RESET = 1'b1;
        req_valid = 1'b0;
        instr_addressIF = '0;
        flush = 1'b0;
        mem_data = '0;
        mem_valid = 1'b0;
        #1;
        chk("rst_hit", 64'(hit), 64'd0);
        chk("rst_mem_req", 64'(mem_req), 64'd0);
        chk("rst_mem_address", 64'(mem_address), 64'd0);
        chk("rst_stall_idle", 64'(stall), 64'd0);
        req_valid = 1'b1;
        #1;
        chk("rst_stall_req", 64'(stall), 64'd1);
        @(negedge CLK);
        @(negedge CLK);
        RESET = 1'b0;
        req_valid = 1'b0;

        access(32'h0000_0040, 1'b1, 2);
        access(32'h0000_005C, 1'b0, 0);
        access(32'h0000_0048, 1'b0, 0);

        // Two-way set 0: C evicts B because A was touched last.
        access(32'h0000_0000, 1'b1, 1);
        access(32'h0000_4000, 1'b1, 3);
        access(32'h0000_0004, 1'b0, 0);
        access(32'h0000_8000, 1'b1, 1);
        access(32'h0000_0000, 1'b0, 0);
        access(32'h0000_8010, 1'b0, 0);
        access(32'h0000_4000, 1'b1, 2);

        // A stray mem_valid in IDLE must not overwrite the last-filled line.
        access(32'h0000_0200, 1'b1, 1);
        @(negedge CLK);
        mem_data  = {8{32'hDEAD_BEEF}};
        mem_valid = 1'b1;
        @(negedge CLK);
        mem_valid = 1'b0;
        access(32'h0000_0214, 1'b0, 0);

        @(negedge CLK);
        flush = 1'b1;
        @(posedge CLK); #1;
        flush = 1'b0;
        flush_wait("flush_cycles", 1'b1);
        access(32'h0000_0040, 1'b1, 1);
        access(32'h0000_0000, 1'b1, 1);
        access(32'h0000_0200, 1'b1, 1);

        // Flush arriving in WAIT; the fetch address moves while the fill is outstanding.
        @(negedge CLK);
        req_valid = 1'b1;
        instr_addressIF = 32'h0000_0300;
        #1;
        chk("fdf_miss", 64'(hit), 64'd0);
        @(posedge CLK); #1;
        chk("fdf_req", 64'(mem_req), 64'd1);
        @(posedge CLK); #1;
        @(negedge CLK);
        flush = 1'b1;
        instr_addressIF = 32'h0000_0600;
        @(posedge CLK); #1;
        flush = 1'b0;
        chk("fdf_addr_hold", 64'(mem_address), 64'h300);
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        mem_data  = gen_line(32'h0000_0300);
        mem_valid = 1'b1;
        @(posedge CLK); #1;
        mem_valid = 1'b0;
        req_valid = 1'b0;
        chk("fdf_req_drop", 64'(mem_req), 64'd0);
        chk("fdf_hit_in_flush", 64'(hit), 64'd0);
        chk("fdf_stall", 64'(stall), 64'd1);
        flush_wait("fdf_flush_cycles", 1'b0);

        // The flushed line misses; reset lands mid-WAIT between clock edges.
        @(negedge CLK);
        req_valid = 1'b1;
        instr_addressIF = 32'h0000_0300;
        #1;
        chk("fdf_line_invalid", 64'(hit), 64'd0);
        @(posedge CLK); #1;
        chk("ar_req", 64'(mem_req), 64'd1);
        @(posedge CLK);
        @(negedge CLK);
        #2;
        RESET = 1'b1;
        #1;
        chk("ar_mem_req", 64'(mem_req), 64'd0);
        chk("ar_mem_address", 64'(mem_address), 64'd0);
        chk("ar_stall", 64'(stall), 64'd1);
        @(negedge CLK);
        RESET = 1'b0;
        req_valid = 1'b0;
        access(32'h0000_0300, 1'b1, 2);
        access(32'h0000_4000, 1'b1, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

`default_nettype wire
